// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM states
// and the elaboration-time width legality check.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A legal operand width is a whole number of nibbles, at least one.
  function automatic bit width_is_legal(input int width);
    return (width >= NIBBLE_W) && ((width % NIBBLE_W) == 0);
  endfunction

endpackage

// File: rtl/adder_4bit.sv
// Four-bit carry-lookahead adder slice. Purely combinational; every carry is
// computed directly from generate/propagate terms instead of rippling.
module Adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract unit that reuses one 4-bit lookahead slice, one
// nibble per cycle, LSB nibble first, with the carry held in a register
// between cycles. Valid/ready handshake on both sides; no overlap of ops.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  if (!width_is_legal(WIDTH)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e              state_q;
  state_e              state_d;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;        // already inverted for subtract
  logic                carry_q;
  logic [IDX_W-1:0]    idx_q;
  logic [WIDTH-1:0]    sum_q;
  logic                cout_q;
  logic                ovf_q;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                last_nib;

  assign slice_a  = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign slice_b  = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign last_nib = (idx_q == IDX_W'(NIB - 1));

  Adder_4bit u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state and handshake outputs, decoded from the current state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and infers a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_nib) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus operand capture and per-nibble result accumulation.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub | in_cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[NIBBLE_W*idx_q +: NIBBLE_W] <= slice_sum;
          carry_q <= slice_cout;
          idx_q   <= last_nib ? '0 : idx_q + IDX_W'(1);
          if (last_nib) begin
            cout_q <= slice_cout;
            // Carry into MSB xor carry out of MSB.
            ovf_q  <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_sum[NIBBLE_W-1]
                    ^ slice_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit add/subtract unit that time-shares a single 4-bit carry-lookahead slice (Adder_4bit), one nibble per cycle, LSB nibble first.
- Carries ripple between cycles through a registered carry.
- Valid/ready handshake on input and output. Sits between an operand source and a result consumer where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4; elaboration error otherwise.
- NIB, WIDTH/4 (derived, localparam), number of nibble iterations.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  unit can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in; ignored when in_sub=1.
- in_sub  input  1  0: A+B+cin; 1: A-B (computed as A + ~B + 1).
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- out_sum  output  WIDTH  result.
- out_cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
- out_ovf  output  1  signed two's-complement overflow.

Behaviour:
- Interface: one clock (clk); reset synchronous, active-low (rst_n). Sampled only on the rising clk edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, nibble index=0, carry reg=0.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready, capture A, B_eff=(in_sub ? ~in_b : in_b), carry=(in_sub ? 1 : in_cin), idx=0, then go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle the slice takes A[4*idx+:4], B_eff[4*idx+:4] and carry. Write the slice sum into out_sum[4*idx+:4]; carry<=slice cout; idx<=idx+1. When idx==NIB-1, also set out_cout=slice cout, set out_ovf (below), and go to DONE.
  - DONE: out_valid=1, in_ready=0, result outputs stable. On out_ready, go to IDLE; out_valid drops the following cycle.
- Latency: accept at edge E; out_valid=1 from edge E+NIB onward (WIDTH=16: 4 edges after accept). Throughput: one operation per NIB+2 cycles at most; no overlap, so in_ready never rises in DONE even if out_ready=1.
- Overflow: out_ovf = A[MSB] ^ B_eff[MSB] ^ sum[MSB] ^ cout (carry into MSB xor carry out), computed in the final RUN cycle.
- Operands are captured at the handshake. Changes to in_a/in_b/in_cin/in_sub after acceptance have no effect.
- in_valid while busy (RUN/DONE) is ignored and not queued; the source must hold it until in_ready.
- out_ready in IDLE/RUN has no effect.
- out_sum/out_cout/out_ovf retain their last value in IDLE (not cleared); only out_valid qualifies them. Partial nibbles are visible during RUN and are not meaningful.
- NIB=1: RUN lasts exactly one cycle; the index counter is at least 1 bit wide.
- Reset mid-operation (RUN or DONE): abort, all state and outputs return to reset values on that edge, no result is emitted, in_ready=1 in the next cycle.

Decomposition:
- Shared package (adder_pkg): state enum (IDLE, RUN, DONE), NIBBLE_W=4 constant, parameter legality check helper.
- One sub-module: an instance of the existing Adder_4bit slice. All sequencing, muxing and registers live in nibble_serial_adder.

Test Plan:
- WIDTH=16, in_a=0x1234, in_b=0x4321, cin=0, sub=0 -> out_sum=0x5555, cout=0, ovf=0, out_valid asserted exactly 4 edges after the accept edge.
- in_a=0xFFFF, in_b=0x0001, cin=0 -> out_sum=0x0000, cout=1, ovf=0. This checks carry propagation across all nibble boundaries.
- in_a=0x7FFF, in_b=0x0001 -> out_sum=0x8000, cout=0, ovf=1. Then in_a=0x0005, in_b=0x0007, sub=1 (cin=1 driven, must be ignored) -> out_sum=0xFFFE, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE and drive in_valid=1 with new operands -> out_valid/out_sum held, in_ready=0, new operands not taken. Release out_ready -> IDLE, then accept the new operands.
- Assert rst_n=0 for one edge during the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, out_sum=0; no out_valid pulse from the aborted op.
- WIDTH=4 instance, in_a=0x9, in_b=0x8, cin=1 -> out_sum=0x2, cout=1, ovf=1, out_valid one edge after accept.
